// File: rtl/sort_pkg.sv
// Shared definitions for the sort loader and unloader stages.
// Pad value, frame state encoding and count-width helper live here.
package sort_pkg;

  localparam int PAD_MAX_W = 64;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Pads must sort to the tail: largest value for ascending, smallest for descending.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input bit ascending, input int data_width);
    logic [PAD_MAX_W-1:0] v;
    v = '0;
    if (ascending) begin
      for (int i = 0; i < PAD_MAX_W; i++) begin
        if (i < data_width) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic int count_width(input int log_input);
    return log_input + 1;
  endfunction

endpackage

// File: rtl/sort_loader.sv
// Packs a valid/ready element stream into one N-element vector per frame,
// padding short frames, and pulses x_valid for one cycle per completed frame.
//
// state   | meaning
// FILL    | accepting elements into slot idx; s_ready high
// EMIT    | frame complete, x/x_count valid for this cycle; s_ready low
module sort_loader
  import sort_pkg::*;
#(
  parameter int LOG_INPUT  = 4,
  parameter int DATA_WIDTH = 8,
  parameter bit ASCENDING  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_last,
  output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] x,
  output logic                                x_valid,
  output logic [LOG_INPUT:0]                  x_count
);

  localparam int N  = 2 ** LOG_INPUT;
  localparam int CW = count_width(LOG_INPUT);
  localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(pad_value(ASCENDING, DATA_WIDTH));
  localparam logic [LOG_INPUT-1:0] LAST_IDX = LOG_INPUT'(N - 1);

  state_t state, state_nxt;
  logic [LOG_INPUT-1:0]  idx;
  logic [DATA_WIDTH-1:0] slots [N];
  logic                  accept;
  logic                  close;

  assign s_ready = (state == ST_FILL) && !rst;
  assign accept  = s_valid && s_ready;
  assign close   = accept && (s_last || (idx == LAST_IDX));
  assign x_valid = (state == ST_EMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (close) state_nxt = ST_EMIT;
      ST_EMIT: state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      x_count <= '0;
    end else if (state == ST_EMIT) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      if (close) x_count <= CW'(idx) + CW'(1);
    end
  end

  // Slots return to PAD on every entry to FILL so unwritten slots of a short frame read as pad.
  for (genvar i = 0; i < N; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst || (state == ST_EMIT))                  slots[i] <= PAD;
      else if (accept && (idx == LOG_INPUT'(i)))      slots[i] <= s_data;
    end
    assign x[DATA_WIDTH*i +: DATA_WIDTH] = slots[i];
  end

endmodule

// File: tb/tb_sort_loader.sv
// Randomized scoreboard bench for sort_loader (N=4, 8-bit) plus a descending-pad instance.
module tb_sort_loader;

  localparam int LI = 2;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, x_valid;
  logic [N*DW-1:0] x;
  logic [LI:0]   x_count;

  logic          d_s_valid = 1'b0, d_s_last = 1'b0;
  logic [DW-1:0] d_s_data = '0;
  logic          d_s_ready, d_x_valid;
  logic [N*DW-1:0] d_x;
  logic [LI:0]   d_x_count;

  sort_loader #(.LOG_INPUT(LI), .DATA_WIDTH(DW), .ASCENDING(1'b1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x(x), .x_valid(x_valid), .x_count(x_count));

  sort_loader #(.LOG_INPUT(LI), .DATA_WIDTH(DW), .ASCENDING(1'b0)) dut_desc (
    .clk(clk), .rst(rst), .s_valid(d_s_valid), .s_ready(d_s_ready), .s_data(d_s_data),
    .s_last(d_s_last), .x(d_x), .x_valid(d_x_valid), .x_count(d_x_count));

  int n_checks = 0;
  int n_fail   = 0;
  int frames_exp = 0;
  int frames_got = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are the accepted elements in order, split at s_last or N elements.
  logic [DW-1:0]   cur[$];
  logic [N*DW-1:0] exp_x_q[$];
  int              exp_c_q[$];

  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    logic [N*DW-1:0] v;
    cur.push_back(d);
    if (l || cur.size() == N) begin
      for (int i = 0; i < N; i++)
        v[DW*i +: DW] = (i < cur.size()) ? cur[i] : 8'hFF;
      exp_x_q.push_back(v);
      exp_c_q.push_back(cur.size());
      frames_exp++;
      cur.delete();
    end
  endtask

  logic prev_xv = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_xv <= 1'b0;
    end else begin
      if (prev_xv) chk("s_ready_after_emit", {63'd0, s_ready}, 64'd1);
      if (x_valid) begin
        frames_got++;
        chk("s_ready_during_emit", {63'd0, s_ready}, 64'd0);
        if (prev_xv) chk("x_valid_back_to_back", 64'd1, 64'd0);
        if (exp_x_q.size() == 0) begin
          chk("unexpected_x_valid", {32'd0, x}, 64'd0);
        end else begin
          chk("x", {32'd0, x}, {32'd0, exp_x_q.pop_front()});
          chk("x_count", {61'd0, x_count}, 64'(exp_c_q.pop_front()));
        end
      end
      prev_xv <= x_valid;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the element is accepted.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int   budget;
    logic rdy;
    budget = 0;
    rdy = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    forever begin
      @(negedge clk); rdy = s_ready;
      @(posedge clk);
      if (rdy) break;
      budget++;
      if (budget > 20) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'($urandom);
    s_data  = 8'($urandom);
    if (rdy) model_accept(d, l);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int len, budget;
    logic [DW-1:0] d;

    // Reset behaviour
    @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_x_valid", {63'd0, x_valid}, 64'd0);
    chk("rst_x_count", {61'd0, x_count}, 64'd0);
    chk("rst_x_pad", {32'd0, x}, 64'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_x_valid", {63'd0, x_valid}, 64'd0);
    chk("post_rst_x_count", {61'd0, x_count}, 64'd0);
    chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;

    // Full frame back-to-back
    send(8'h05, 1'b0); send(8'h01, 1'b0); send(8'h07, 1'b0); send(8'h03, 1'b0);
    idle(2);

    // Short frame closed by s_last
    send(8'h09, 1'b0); send(8'h02, 1'b1);
    idle(3);

    // s_last on the Nth element, then a new frame starting at slot 0
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    send(8'h55, 1'b1);
    idle(2);

    // Reset mid-frame discards the partial frame
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    cur.delete();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
    idle(2);

    // Randomized frames with random gaps and stray s_last while idle
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, N);
      for (int k = 0; k < len; k++) begin
        d = 8'($urandom);
        send(d, (k == len - 1) && (len < N || $urandom_range(0, 1) == 1));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end

    // Drain
    budget = 0;
    while (exp_x_q.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    idle(2);
    chk("scoreboard_drained", 64'(exp_x_q.size()), 64'd0);
    chk("frame_count", 64'(frames_got), 64'(frames_exp));
    chk("no_partial_left", 64'(cur.size()), 64'd0);

    // Descending pad: single element closes the frame
    d_s_valid = 1'b1; d_s_data = 8'h40; d_s_last = 1'b1;
    @(negedge clk);
    chk("desc_s_ready", {63'd0, d_s_ready}, 64'd1);
    @(posedge clk); #1;
    d_s_valid = 1'b0; d_s_last = 1'b0;
    @(negedge clk);
    chk("desc_x_valid", {63'd0, d_x_valid}, 64'd1);
    chk("desc_x", {32'd0, d_x}, 64'h0000_0040);
    chk("desc_x_count", {61'd0, d_x_count}, 64'd1);
    @(negedge clk);
    chk("desc_x_valid_pulse", {63'd0, d_x_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
